icebus_status_frame_rx: RTL and testbench
=========================================

Name: icebus_status_frame_rx

Overview:
- Byte-stream frame receiver sitting directly downstream of uart_rx and upstream of the arm-bus master's status bookkeeping.
- Hunts for the 4-byte status-response header and captures a fixed-length hand-status frame.
- Checks CRC16 (x^16+x^15+x^2+1, init 16'hFFFF, first serial bit = D[7]) and the motor id, then presents decoded fields with a one-cycle valid strobe and error strobes.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; documentation only, no logic depends on it.
- HEADER, 32'h1CEB00DA, magic number; the first received byte matches HEADER[31:24].
- FRAME_LENGTH, 21, total frame bytes: header(4) id(1) enc0(3) enc1(3) displacement(3) current(2) duty(3) crc(2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte from uart_rx
- rx_data_ready  in  1  uart_rx strobe; may be multi-cycle; only its rising edge accepts a byte
- expected_id  in  8  id of the motor most recently polled
- byte_timeout_cycles  in  32  maximum clk cycles between payload bytes; 0 disables the timeout
- abort  in  1  master timeout; drops any frame in progress
- busy  out  1  high in RECEIVE or CHECK
- frame_valid  out  1  one-cycle pulse: good frame
- crc_error  out  1  one-cycle pulse
- id_mismatch  out  1  one-cycle pulse: CRC good, id differs from expected_id
- timeout_error  out  1  one-cycle pulse
- id  out  8  received id
- encoder0_position  out  24 signed
- encoder1_position  out  24 signed
- displacement  out  24 signed
- current  out  16 signed
- duty  out  24 signed
- rx_crc  out  16  last computed CRC, for debug
- frames_ok  out  32  good-frame counter
- crc_errors  out  16  saturating CRC-error counter

Behaviour:
- Byte accept: registered rx_data_ready_prev; a byte is accepted on a cycle with rx_data_ready=1 and rx_data_ready_prev=0.
- Reset: state=HUNT, shift register cleared to 0, all outputs 0, counters 0.
- HUNT:
  - Each accepted byte shifts into a 32-bit register (new byte enters the LSB).
  - When the register including the current byte equals HEADER, go to RECEIVE with idx=0 and crc=16'hFFFF.
- RECEIVE:
  - Each accepted byte is written to payload[idx] and idx increments.
  - While idx < FRAME_LENGTH-6 (15 bytes), crc=nextCRC16_D8(byte, crc). The CRC covers id..duty only; the header is excluded.
  - Timer reloads to byte_timeout_cycles on entry and on every accepted byte; otherwise it decrements.
  - Timer reaching 0 with a nonzero limit pulses timeout_error and returns to HUNT.
  - After the byte with idx = FRAME_LENGTH-5 (the last CRC byte), go to CHECK.
- CHECK (exactly one cycle):
  - Received CRC = {payload[15], payload[16]}, MSB first.
  - Match and id==expected_id: latch all fields big-endian (id=payload[0], enc0=payload[1..3], enc1=[4..6], displacement=[7..9], current=[10..11], duty=[12..14]); frame_valid=1 next cycle; frames_ok+1, wrapping.
  - Match and id differs: id_mismatch pulse; fields not updated.
  - No match: crc_error pulse; crc_errors+1, saturating at 16'hFFFF; fields not updated.
  - rx_crc is updated in all three cases.
  - Always return to HUNT with the shift register cleared, so payload bytes are never reused as a header.
- Latency: last CRC byte accepted at edge N → CHECK during cycle N..N+1 → strobe high for the single cycle after edge N+1.
- Fields hold their last good values between frames.
- Boundaries:
  - abort in any state → HUNT and clear the shift register next edge, no error strobe. Abort wins over a simultaneous byte, which is discarded.
  - A byte accepted during CHECK shifts into the freshly cleared hunt register.
  - A header pattern appearing inside the payload is ignored; bytes are stored as data.
  - reset mid-frame → HUNT, all strobes low.
  - At most one strobe is high per cycle.

Optional Feature:
- ICEBUS_RX_STATS_EN defined: frames_ok and crc_errors are implemented as above.
- Not defined: both outputs are tied to 0 and the counter registers are removed. All other behaviour is unchanged.

Test Plan:
- Good frame: header 1C EB 00 DA, id 05, enc0 00 01 00, enc1 FF FF FE, disp 00 00 0A, current 01 2C, duty FF FC 18, CRC from golden model, expected_id=5 → frame_valid one cycle after CHECK; enc0=256, enc1=-2, displacement=10, current=300, duty=-1000; frames_ok=1.
- Same frame with one payload bit flipped → crc_error pulse, crc_errors=1, fields retain previous values, frame_valid stays 0.
- Valid frame with id 07 while expected_id=5 → id_mismatch pulse only, frames_ok unchanged.
- byte_timeout_cycles=100, stream stops after 8 payload bytes → timeout_error at cycle 100 after the last byte; the next complete frame is received correctly.
- Garbage AA 1C 1C EB 00 DA followed by a frame → header is found despite the false start; abort asserted mid-frame → no strobe, then a clean frame is accepted.
- rx_data_ready held high for 5 cycles per byte → each byte counted exactly once; crc_errors saturates at FFFF after 65536+ bad frames (stats build only).

Source files
------------

// File: rtl/icebus_status_frame_rx.sv
// Icebus hand-status frame receiver: hunts for the response header, captures the payload,
// checks CRC16 and motor id, then presents decoded fields. Counters gated by ICEBUS_RX_STATS_EN.
module icebus_status_frame_rx #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter logic [31:0] HEADER       = 32'h1CEB00DA,
  parameter int unsigned FRAME_LENGTH = 21
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_data_ready,
  input  logic [7:0]         expected_id,
  input  logic [31:0]        byte_timeout_cycles,
  input  logic               abort,
  output logic               busy,
  output logic               frame_valid,
  output logic               crc_error,
  output logic               id_mismatch,
  output logic               timeout_error,
  output logic [7:0]         id,
  output logic signed [23:0] encoder0_position,
  output logic signed [23:0] encoder1_position,
  output logic signed [23:0] displacement,
  output logic signed [15:0] current,
  output logic signed [23:0] duty,
  output logic [15:0]        rx_crc,
  output logic [31:0]        frames_ok,
  output logic [15:0]        crc_errors
);

  localparam int unsigned PAYLOAD_LEN = FRAME_LENGTH - 4;
  localparam int unsigned CRC_LEN     = FRAME_LENGTH - 6;
  localparam int unsigned IDX_W       = 5;
  localparam logic [IDX_W-1:0] CRC_IDX  = IDX_W'(CRC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

  typedef enum logic [1:0] {HUNT, RECEIVE, CHECK} state_t;

  logic [31:0] unused_clk_freq;
  assign unused_clk_freq = 32'(CLK_FREQ_HZ);

  state_t           state, state_d;
  logic             rx_data_ready_prev;
  logic [31:0]      shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      crc_q, crc_d;
  logic [31:0]      timer_q, timer_d;
  logic [7:0]       payload [PAYLOAD_LEN];
  logic             accept;
  logic             pay_we, latch_fields, rx_crc_we;
  logic             ok_d, crc_err_d, mism_d, to_d;

  // CRC16 x^16+x^15+x^2+1, MSB of the byte shifted in first
  function automatic logic [15:0] crc16_d8(input logic [7:0] d, input logic [15:0] c);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign accept = rx_data_ready && !rx_data_ready_prev;

  always_comb begin
    state_d      = state;
    shift_d      = shift_q;
    idx_d        = idx_q;
    crc_d        = crc_q;
    timer_d      = timer_q;
    pay_we       = 1'b0;
    latch_fields = 1'b0;
    rx_crc_we    = 1'b0;
    ok_d         = 1'b0;
    crc_err_d    = 1'b0;
    mism_d       = 1'b0;
    to_d         = 1'b0;
    case (state)
      HUNT: begin
        if (accept) begin
          shift_d = {shift_q[23:0], rx_data};
          if (shift_d == HEADER) begin
            state_d = RECEIVE;
            idx_d   = '0;
            crc_d   = 16'hFFFF;
            timer_d = byte_timeout_cycles;
          end
        end
      end
      RECEIVE: begin
        if (accept) begin
          pay_we  = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          timer_d = byte_timeout_cycles;
          if (idx_q < CRC_IDX) crc_d = crc16_d8(rx_data, crc_q);
          if (idx_q == LAST_IDX) state_d = CHECK;
        end else if (byte_timeout_cycles != 32'd0) begin
          if (timer_q <= 32'd1) begin
            to_d    = 1'b1;
            state_d = HUNT;
            shift_d = '0;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
      end
      CHECK: begin
        state_d   = HUNT;
        shift_d   = accept ? {24'd0, rx_data} : 32'd0;
        rx_crc_we = 1'b1;
        if (crc_q == {payload[CRC_LEN], payload[CRC_LEN+1]}) begin
          if (payload[0] == expected_id) begin
            ok_d         = 1'b1;
            latch_fields = 1'b1;
          end else begin
            mism_d = 1'b1;
          end
        end else begin
          crc_err_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
    // Abort drops everything, including a byte arriving on the same edge
    if (abort) begin
      state_d      = HUNT;
      shift_d      = '0;
      pay_we       = 1'b0;
      latch_fields = 1'b0;
      rx_crc_we    = 1'b0;
      ok_d         = 1'b0;
      crc_err_d    = 1'b0;
      mism_d       = 1'b0;
      to_d         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= HUNT;
      rx_data_ready_prev <= 1'b0;
      shift_q            <= '0;
      idx_q              <= '0;
      crc_q              <= 16'hFFFF;
      timer_q            <= '0;
      for (int i = 0; i < int'(PAYLOAD_LEN); i++) payload[i] <= '0;
      busy               <= 1'b0;
      frame_valid        <= 1'b0;
      crc_error          <= 1'b0;
      id_mismatch        <= 1'b0;
      timeout_error      <= 1'b0;
      id                 <= '0;
      encoder0_position  <= '0;
      encoder1_position  <= '0;
      displacement       <= '0;
      current            <= '0;
      duty               <= '0;
      rx_crc             <= '0;
    end else begin
      state              <= state_d;
      rx_data_ready_prev <= rx_data_ready;
      shift_q            <= shift_d;
      idx_q              <= idx_d;
      crc_q              <= crc_d;
      timer_q            <= timer_d;
      if (pay_we) payload[idx_q] <= rx_data;
      busy               <= (state_d != HUNT);
      frame_valid        <= ok_d;
      crc_error          <= crc_err_d;
      id_mismatch        <= mism_d;
      timeout_error      <= to_d;
      if (rx_crc_we) rx_crc <= crc_q;
      // Big-endian field decode, only from a fully verified frame
      if (latch_fields) begin
        id                <= payload[0];
        encoder0_position <= {payload[1], payload[2], payload[3]};
        encoder1_position <= {payload[4], payload[5], payload[6]};
        displacement      <= {payload[7], payload[8], payload[9]};
        current           <= {payload[10], payload[11]};
        duty              <= {payload[12], payload[13], payload[14]};
      end
    end
  end

`ifdef ICEBUS_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_ok  <= '0;
      crc_errors <= '0;
    end else begin
      if (ok_d) frames_ok <= frames_ok + 32'd1;
      if (crc_err_d && crc_errors != 16'hFFFF) crc_errors <= crc_errors + 16'd1;
    end
  end
`else
  assign frames_ok  = '0;
  assign crc_errors = '0;
`endif

endmodule

// File: tb/tb_icebus_status_frame_rx.sv
// Self-checking bench for icebus_status_frame_rx: random frames against a field/outcome model.
module tb_icebus_status_frame_rx;

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         rx_data;
  logic               rx_data_ready;
  logic [7:0]         expected_id;
  logic [31:0]        byte_timeout_cycles;
  logic               abort;
  logic               busy, frame_valid, crc_error, id_mismatch, timeout_error;
  logic [7:0]         id;
  logic signed [23:0] encoder0_position, encoder1_position, displacement, duty;
  logic signed [15:0] current;
  logic [15:0]        rx_crc;
  logic [31:0]        frames_ok;
  logic [15:0]        crc_errors;

  icebus_status_frame_rx dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .expected_id(expected_id), .byte_timeout_cycles(byte_timeout_cycles), .abort(abort),
    .busy(busy), .frame_valid(frame_valid), .crc_error(crc_error), .id_mismatch(id_mismatch),
    .timeout_error(timeout_error), .id(id), .encoder0_position(encoder0_position),
    .encoder1_position(encoder1_position), .displacement(displacement), .current(current),
    .duty(duty), .rx_crc(rx_crc), .frames_ok(frames_ok), .crc_errors(crc_errors)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, last_acc = 0, to_cyc = 0;
  bit tb_prev = 1'b0;
  int n_fv = 0, n_ce = 0, n_im = 0, n_to = 0;
  int e_fv = 0, e_ce = 0, e_im = 0, e_to = 0;

  // Model of the decoded outputs
  logic [7:0]  m_id;
  logic [23:0] m_e0, m_e1, m_d, m_du;
  logic [15:0] m_cu;
  logic [31:0] m_ok;
  logic [15:0] m_cerr;

  // Stimulus frame
  logic [7:0]  f_id;
  logic [23:0] f_e0, f_e1, f_d, f_du;
  logic [15:0] f_cu;
  logic [7:0]  frame [21];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rx_data_ready && !tb_prev) last_acc = cyc;
    tb_prev = rx_data_ready;
  end

  always @(posedge clk) begin
    int s;
    #1;
    s = int'(frame_valid) + int'(crc_error) + int'(id_mismatch) + int'(timeout_error);
    if (s > 0) begin
      checks++;
      if (s > 1) begin
        errors++;
        $display("FAIL one_strobe cycle %0d: %0d strobes high, required 1", cyc, s);
      end
    end
    n_fv += int'(frame_valid);
    n_ce += int'(crc_error);
    n_im += int'(id_mismatch);
    n_to += int'(timeout_error);
    if (timeout_error) to_cyc = cyc;
  end

  function automatic logic [167:0] dut_fields();
    return {id, encoder0_position, encoder1_position, displacement, current, duty,
            frames_ok, crc_errors};
  endfunction

  function automatic logic [167:0] model_fields();
`ifdef ICEBUS_RX_STATS_EN
    return {m_id, m_e0, m_e1, m_d, m_cu, m_du, m_ok, m_cerr};
`else
    return {m_id, m_e0, m_e1, m_d, m_cu, m_du, 48'h0};
`endif
  endfunction

  function automatic logic [63:0] dut_counts();
    return {16'(n_fv), 16'(n_ce), 16'(n_im), 16'(n_to)};
  endfunction

  function automatic logic [63:0] model_counts();
    return {16'(e_fv), 16'(e_ce), 16'(e_im), 16'(e_to)};
  endfunction

  // Table-driven reference CRC (polynomial 0x8005, non-reflected, init FFFF)
  function automatic logic [15:0] crc_tab(input logic [7:0] i);
    logic [15:0] c;
    c = {i, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    return c;
  endfunction

  task automatic model_reset();
    m_id = '0; m_e0 = '0; m_e1 = '0; m_d = '0; m_cu = '0; m_du = '0; m_ok = '0; m_cerr = '0;
  endtask

  task automatic build_frame(input bit corrupt);
    logic [15:0] c;
    int pos, b;
    frame[0] = 8'h1C; frame[1] = 8'hEB; frame[2] = 8'h00; frame[3] = 8'hDA;
    frame[4] = f_id;
    {frame[5], frame[6], frame[7]}    = f_e0;
    {frame[8], frame[9], frame[10]}   = f_e1;
    {frame[11], frame[12], frame[13]} = f_d;
    {frame[14], frame[15]}            = f_cu;
    {frame[16], frame[17], frame[18]} = f_du;
    c = 16'hFFFF;
    for (int i = 4; i <= 18; i++) c = (c << 8) ^ crc_tab(c[15:8] ^ frame[i]);
    frame[19] = c[15:8];
    frame[20] = c[7:0];
    if (corrupt) begin
      pos = int'($urandom_range(4, 20));
      b   = int'($urandom_range(0, 7));
      frame[pos][b] = ~frame[pos][b];
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_data_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  task automatic rand_fields();
    f_e0 = 24'($urandom); f_e1 = 24'($urandom); f_d = 24'($urandom);
    f_cu = 16'($urandom); f_du = 24'($urandom);
  endtask

  // Sends a full frame and records the outcome the model predicts
  task automatic run_frame(input int hold, input bit corrupt);
    build_frame(corrupt);
    for (int i = 0; i < 21; i++) send_byte(frame[i], hold);
    if (corrupt) begin
      e_ce++;
      if (m_cerr != 16'hFFFF) m_cerr = m_cerr + 16'd1;
    end else if (f_id == expected_id) begin
      e_fv++;
      m_ok = m_ok + 32'd1;
      m_id = f_id; m_e0 = f_e0; m_e1 = f_e1; m_d = f_d; m_cu = f_cu; m_du = f_du;
    end else begin
      e_im++;
    end
  endtask

  task automatic test_reset();
    model_reset();
    checks++;
    if ({busy, frame_valid, crc_error, id_mismatch, timeout_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {busy, frame_valid, crc_error, id_mismatch, timeout_error});
    end
    checks++;
    if (dut_fields() !== model_fields() || rx_crc !== 16'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h/%h required %h/0000", dut_fields(), rx_crc, model_fields());
    end
  endtask

  task automatic test_good_frame();
    expected_id = 8'd5;
    f_id = 8'h05; f_e0 = 24'h000100; f_e1 = 24'hFFFFFE; f_d = 24'h00000A;
    f_cu = 16'h012C; f_du = 24'hFFFC18;
    run_frame(1, 1'b0);
    checks++;
    if (busy !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_check_cycle: busy %b valid %b required 1 0", busy, frame_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL good_latency: frame_valid %b required 1", frame_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_pulse_width: frame_valid %b required 0", frame_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (encoder0_position !== 24'sd256 || encoder1_position !== -24'sd2 ||
        displacement !== 24'sd10 || current !== 16'sd300 || duty !== -24'sd1000) begin
      errors++;
      $display("FAIL good_values: enc0 %0d enc1 %0d disp %0d cur %0d duty %0d required 256 -2 10 300 -1000",
               encoder0_position, encoder1_position, displacement, current, duty);
    end
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL good_model: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_crc_error();
    run_frame(int'($urandom_range(1, 3)), 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL crc_error: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_id_mismatch();
    f_id = 8'h07;
    rand_fields();
    run_frame(2, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL id_mismatch: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_timeout();
    int i;
    byte_timeout_cycles = 32'd100;
    f_id = expected_id;
    rand_fields();
    build_frame(1'b0);
    for (int k = 0; k < 12; k++) send_byte(frame[k], 1);
    i = 0;
    while (n_to == e_to && i < 200) begin
      @(negedge clk);
      i++;
    end
    e_to++;
    checks++;
    if (dut_counts() !== model_counts() || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_strobe: counts %h busy %b required %h 0", dut_counts(), busy, model_counts());
    end
    checks++;
    if (to_cyc - last_acc != 100) begin
      errors++;
      $display("FAIL timeout_delay: %0d cycles required 100", to_cyc - last_acc);
    end
    rand_fields();
    run_frame(1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL timeout_recover: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_garbage_abort();
    send_byte(8'hAA, 1);
    send_byte(8'h1C, 1);
    f_id = expected_id;
    rand_fields();
    run_frame(1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL false_start: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
    rand_fields();
    build_frame(1'b0);
    for (int k = 0; k < 10; k++) send_byte(frame[k], 1);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: busy %b required 0", busy);
    end
    for (int k = 10; k < 21; k++) send_byte(frame[k], 1);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL abort_quiet: counts %h required %h", dut_counts(), model_counts());
    end
    rand_fields();
    run_frame(2, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL abort_recover: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_header_in_payload();
    f_id = expected_id;
    rand_fields();
    f_e0 = 24'h1CEB00;
    f_e1 = {8'hDA, 16'($urandom)};
    run_frame(1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL header_in_payload: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_multicycle_ready();
    f_id = expected_id;
    rand_fields();
    run_frame(5, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL multicycle_ready: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_reset_midframe();
    f_id = expected_id;
    rand_fields();
    build_frame(1'b0);
    for (int k = 0; k < 12; k++) send_byte(frame[k], 2);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++;
    if ({busy, frame_valid, crc_error, id_mismatch, timeout_error} !== 5'b0 ||
        dut_fields() !== model_fields()) begin
      errors++;
      $display("FAIL reset_midframe: ctrl %b fields %h required 00000 %h",
               {busy, frame_valid, crc_error, id_mismatch, timeout_error}, dut_fields(), model_fields());
    end
    rand_fields();
    run_frame(1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
      errors++;
      $display("FAIL reset_recover: got %h/%h required %h/%h",
               dut_fields(), dut_counts(), model_fields(), model_counts());
    end
  endtask

  task automatic test_back_to_back();
    int kind;
    for (int n = 0; n < 20; n++) begin
      expected_id = 8'($urandom);
      kind = int'($urandom_range(0, 2));
      f_id = (kind == 1) ? expected_id + 8'd1 : expected_id;
      rand_fields();
      run_frame(int'($urandom_range(1, 5)), kind == 2);
      repeat (4) @(negedge clk);
      checks++;
      if (dut_fields() !== model_fields() || dut_counts() !== model_counts()) begin
        errors++;
        $display("FAIL back_to_back[%0d] kind %0d: got %h/%h required %h/%h", n, kind,
                 dut_fields(), dut_counts(), model_fields(), model_counts());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 8'h00;
    rx_data_ready = 1'b0;
    expected_id = 8'd5;
    byte_timeout_cycles = 32'd0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_crc_error();
    test_id_mismatch();
    test_timeout();
    test_garbage_abort();
    test_header_in_payload();
    test_multicycle_ready();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
